// File: rtl/ff_bank_univ_pkg.sv
// Shared mode encodings for the universal flip-flop bank and its bench.
package ff_pkg;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  typedef logic [1:0] ff_mode_t;

  // True when an SR channel sees both inputs high.
  function automatic logic sr_illegal(input ff_mode_t mode, input logic s, input logic r);
    return (mode == MODE_SR) && s && r;
  endfunction

endpackage

// File: rtl/ff_cell_univ.sv
// One run-time configurable storage channel (D/T/JK/SR) with sticky illegal-SR flag.
module ff_cell_univ
  import ff_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en,
  input  ff_mode_t mode,
  input  logic     a,
  input  logic     b,
  input  logic     err_clr,
  input  logic     rst_val,
  output logic     q,
  output logic     qn,
  output logic     err
);

  logic illegal;

  always_comb begin
    qn = q;
    case (mode)
      MODE_D:  qn = a;
      MODE_T:  qn = q ^ a;
      MODE_JK: begin
        case ({a, b})
          2'b01:   qn = 1'b0;
          2'b10:   qn = 1'b1;
          2'b11:   qn = ~q;
          default: qn = q;
        endcase
      end
      default: begin
        // SR: both-high is treated as hold; the error flag records it.
        case ({a, b})
          2'b01:   qn = 1'b0;
          2'b10:   qn = 1'b1;
          default: qn = q;
        endcase
      end
    endcase
  end

  assign illegal = en && sr_illegal(mode, a, b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= rst_val;
      err <= 1'b0;
    end else begin
      if (en) q <= qn;
      // A new detection on the same edge outranks the clear.
      if (illegal)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: rtl/ff_bank_univ.sv
// WIDTH-channel bank of universal flip-flops with complementary outputs and change pulse.
module ff_bank_univ
  import ff_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] err,
  output logic             chg
);

  logic [WIDTH-1:0] qn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell_univ u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode),
      .a       (a[i]),
      .b       (b[i]),
      .err_clr (err_clr),
      .rst_val (RST_VAL[i]),
      .q       (q[i]),
      .qn      (qn[i]),
      .err     (err[i])
    );
  end

  assign qb = ~q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chg <= 1'b0;
    else        chg <= en && (|(qn ^ q));
  end

endmodule

// File: tb/tb_ff_bank_univ.sv
// Directed-vector bench for ff_bank_univ (WIDTH=4, RST_VAL=4'b1010).
module tb_ff_bank_univ;
  import ff_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] a, b;
  logic       err_clr;
  logic [3:0] q, qb, err;
  logic       chg;

  int n_tests = 0;
  int n_fail  = 0;

  ff_bank_univ #(.WIDTH(4), .RST_VAL(4'b1010)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
    .err_clr(err_clr), .q(q), .qb(qb), .err(err), .chg(chg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; mode = MODE_D; a = '0; b = '0; err_clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (q !== 4'b1010) begin n_fail++; $display("FAIL reset_q got=%b exp=1010", q); end
    n_tests++; if (qb !== 4'b0101) begin n_fail++; $display("FAIL reset_qb got=%b exp=0101", qb); end
    n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL reset_err got=%b exp=0000", err); end
    n_tests++; if (chg !== 1'b0) begin n_fail++; $display("FAIL reset_chg got=%b exp=0", chg); end
    en = 1'b1; a = 4'b1111;
    tick(); tick(); tick();
    n_tests++; if ({q, err, chg} !== {4'b1010, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL reset_hold got q=%b err=%b chg=%b exp q=1010 err=0000 chg=0", q, err, chg);
    end
    en = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_d();
    mode = MODE_D; en = 1'b1; a = 4'b0110;
    tick();
    n_tests++; if (q !== 4'b0110) begin n_fail++; $display("FAIL d_load got=%b exp=0110", q); end
    n_tests++; if (qb !== 4'b1001) begin n_fail++; $display("FAIL d_qb got=%b exp=1001", qb); end
    n_tests++; if (chg !== 1'b1) begin n_fail++; $display("FAIL d_chg got=%b exp=1", chg); end
    tick();
    n_tests++; if (chg !== 1'b0) begin n_fail++; $display("FAIL d_repeat_chg got=%b exp=0", chg); end
    en = 1'b0; a = 4'b1111;
    tick();
    n_tests++; if (q !== 4'b0110) begin n_fail++; $display("FAIL d_en0_q got=%b exp=0110", q); end
    n_tests++; if (chg !== 1'b0) begin n_fail++; $display("FAIL d_en0_chg got=%b exp=0", chg); end
  endtask

  task automatic test_t();
    mode = MODE_T; en = 1'b1; a = 4'b0011;
    tick();
    n_tests++; if (q !== 4'b0101) begin n_fail++; $display("FAIL t_first got=%b exp=0101", q); end
    tick();
    n_tests++; if (q !== 4'b0110) begin n_fail++; $display("FAIL t_second got=%b exp=0110", q); end
    n_tests++; if (chg !== 1'b1) begin n_fail++; $display("FAIL t_chg got=%b exp=1", chg); end
    a = 4'b0000;
    tick();
    n_tests++; if ({q, chg} !== {4'b0110, 1'b0}) begin
      n_fail++; $display("FAIL t_hold got q=%b chg=%b exp q=0110 chg=0", q, chg);
    end
  endtask

  task automatic test_jk();
    mode = MODE_D; en = 1'b1; a = 4'b0000;
    tick();
    mode = MODE_JK; a = 4'b1100; b = 4'b1010;
    tick();
    n_tests++; if (q !== 4'b1100) begin n_fail++; $display("FAIL jk_mix got=%b exp=1100", q); end
    n_tests++; if (chg !== 1'b1) begin n_fail++; $display("FAIL jk_chg got=%b exp=1", chg); end
    a = 4'b1111; b = 4'b1111;
    tick();
    n_tests++; if (q !== 4'b0011) begin n_fail++; $display("FAIL jk_toggle got=%b exp=0011", q); end
    n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL jk_no_err got=%b exp=0000", err); end
  endtask

  task automatic test_sr();
    mode = MODE_D; en = 1'b1; a = 4'b0000; b = 4'b0000;
    tick();
    mode = MODE_SR; a = 4'b1001; b = 4'b0011;
    tick();
    n_tests++; if (q !== 4'b1000) begin n_fail++; $display("FAIL sr_q got=%b exp=1000", q); end
    n_tests++; if (err !== 4'b0001) begin n_fail++; $display("FAIL sr_err got=%b exp=0001", err); end
    err_clr = 1'b1; a = 4'b0001; b = 4'b0001;
    tick();
    n_tests++; if (err !== 4'b0001) begin n_fail++; $display("FAIL sr_set_wins got=%b exp=0001", err); end
    n_tests++; if ({q, chg} !== {4'b1000, 1'b0}) begin
      n_fail++; $display("FAIL sr_11_hold got q=%b chg=%b exp q=1000 chg=0", q, chg);
    end
    a = 4'b0000; b = 4'b0000;
    tick();
    n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL sr_clear got=%b exp=0000", err); end
    err_clr = 1'b0; en = 1'b0; a = 4'b0100; b = 4'b0100;
    tick();
    n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL sr_en0_no_err got=%b exp=0000", err); end
    en = 1'b1;
    tick();
    n_tests++; if (err !== 4'b0100) begin n_fail++; $display("FAIL sr_err2 got=%b exp=0100", err); end
    en = 1'b0; err_clr = 1'b1; a = 4'b0000; b = 4'b0000;
    tick();
    n_tests++; if (err !== 4'b0000) begin n_fail++; $display("FAIL sr_clr_en0 got=%b exp=0000", err); end
    err_clr = 1'b0;
  endtask

  task automatic test_mode_switch();
    en = 1'b1; mode = MODE_D; a = 4'b1111; b = 4'b0000;
    tick();
    mode = MODE_SR; a = 4'b0001; b = 4'b0001;
    tick();
    n_tests++; if ({q, err} !== {4'b1111, 4'b0001}) begin
      n_fail++; $display("FAIL sw_setup got q=%b err=%b exp q=1111 err=0001", q, err);
    end
    mode = MODE_T; a = 4'b1111; b = 4'b0000;
    tick();
    n_tests++; if (q !== 4'b0000) begin n_fail++; $display("FAIL sw_t got=%b exp=0000", q); end
    mode = MODE_D; a = 4'b0101;
    tick();
    n_tests++; if (q !== 4'b0101) begin n_fail++; $display("FAIL sw_d got=%b exp=0101", q); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({q, qb, err, chg} !== {4'b1010, 4'b0101, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL sw_reset got q=%b qb=%b err=%b chg=%b exp 1010 0101 0000 0", q, qb, err, chg);
    end
    a = 4'b0011;
    #3 rst_n = 1'b1;
    tick();
    n_tests++; if ({q, chg} !== {4'b0011, 1'b1}) begin
      n_fail++; $display("FAIL sw_first_edge got q=%b chg=%b exp q=0011 chg=1", q, chg);
    end
  endtask

  initial begin
    test_reset();
    test_d();
    test_t();
    test_jk();
    test_sr();
    test_mode_switch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
